// File: rtl/led_ctrl.sv
// Register-programmable LED driver: static pattern, per-channel blink, global PWM brightness.
// Latency: register write at edge k reaches LED_data at edge k+1; rd is combinational.
// Backpressure: none; writes are accepted every cycle and never stall the counters.
module led_ctrl #(
    parameter int NUM_LED = 8,
    parameter int PRESC_W = 16,
    parameter int PWM_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [31:0]        wd,
    output logic [31:0]        rd,
    output logic [NUM_LED-1:0] LED_data
);

    localparam logic [1:0]       A_DATA    = 2'd0;
    localparam logic [1:0]       A_BLINK   = 2'd1;
    localparam logic [1:0]       A_PRESC   = 2'd2;
    localparam logic [1:0]       A_DUTY    = 2'd3;
    localparam logic [PWM_W-1:0] DUTY_FULL = '1;

    logic [NUM_LED-1:0] data_q;
    logic [NUM_LED-1:0] blink_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PWM_W-1:0]   duty_q;
    logic [PRESC_W-1:0] presc_cnt;
    logic [PWM_W-1:0]   pwm_cnt;
    logic               blink_phase;
    logic               wr_presc;
    logic               pwm_on;
    logic [NUM_LED-1:0] blink_gate;
    logic [NUM_LED-1:0] led_nxt;

    assign wr_presc = we && (addr == A_PRESC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '1;
            blink_q <= '0;
            presc_q <= '1;
            duty_q  <= '1;
        end else if (we) begin
            case (addr)
                A_DATA:  data_q  <= wd[NUM_LED-1:0];
                A_BLINK: blink_q <= wd[NUM_LED-1:0];
                A_PRESC: presc_q <= wd[PRESC_W-1:0];
                A_DUTY:  duty_q  <= wd[PWM_W-1:0];
                default: ;
            endcase
        end
    end

    // A PRESC write restarts the countdown but must not disturb blink_phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt   <= '1;
            pwm_cnt     <= '0;
            blink_phase <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (wr_presc) begin
                presc_cnt <= wd[PRESC_W-1:0];
            end else if (presc_cnt == '0) begin
                presc_cnt   <= presc_q;
                blink_phase <= ~blink_phase;
            end else begin
                presc_cnt <= presc_cnt - PRESC_W'(1);
            end
        end
    end

    always_comb begin
        pwm_on     = (duty_q == DUTY_FULL) || (pwm_cnt < duty_q);
        blink_gate = blink_phase ? {NUM_LED{1'b1}} : ~blink_q;
        led_nxt    = data_q & blink_gate & {NUM_LED{pwm_on}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LED_data <= '1;
        end else begin
            LED_data <= led_nxt;
        end
    end

    always_comb begin
        rd = '0;
        case (addr)
            A_DATA:  rd[NUM_LED-1:0] = data_q;
            A_BLINK: rd[NUM_LED-1:0] = blink_q;
            A_PRESC: rd[PRESC_W-1:0] = presc_q;
            A_DUTY:  rd[PWM_W-1:0]   = duty_q;
            default: rd = '0;
        endcase
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl: reference model feeds an expected-LED queue, plus directed checks.
module tb_led_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  LED_data;

    led_ctrl #(.NUM_LED(8), .PRESC_W(16), .PWM_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .addr     (addr),
        .wd       (wd),
        .rd       (rd),
        .LED_data (LED_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model of the register file, counters and LED output.
    logic [7:0]  m_data, m_blink, m_led;
    logic [15:0] m_presc, m_pcnt;
    logic [3:0]  m_duty, m_pwm;
    logic        m_phase, m_on;
    logic [7:0]  exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data = 8'hFF; m_blink = 8'h00; m_presc = 16'hFFFF; m_duty = 4'hF;
            m_pcnt = 16'hFFFF; m_pwm = 4'h0; m_phase = 1'b1;
            exp_q.delete();
        end else begin
            m_on  = (m_duty == 4'hF) ? 1'b1 : (m_duty != 0 && m_pwm < m_duty);
            m_led = 8'h00;
            for (int i = 0; i < 8; i++)
                m_led[i] = m_data[i] && (m_blink[i] ? m_phase : 1'b1) && m_on;
            exp_q.push_back(m_led);
            m_pwm = (m_pwm == 4'hF) ? 4'h0 : m_pwm + 4'h1;
            if (we && addr == 2'd2) m_pcnt = wd[15:0];
            else if (m_pcnt == 0) begin m_pcnt = m_presc; m_phase = !m_phase; end
            else m_pcnt = m_pcnt - 16'h1;
            if (we) begin
                if (addr == 2'd0) m_data  = wd[7:0];
                if (addr == 2'd1) m_blink = wd[7:0];
                if (addr == 2'd2) m_presc = wd[15:0];
                if (addr == 2'd3) m_duty  = wd[3:0];
            end
        end
    end

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {24'h0, m_data};
            2'd1:    return {24'h0, m_blink};
            2'd2:    return {16'h0, m_presc};
            default: return {28'h0, m_duty};
        endcase
    endfunction

    // Scoreboard: compare the LED value predicted at the last edge.
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) check("led_model", {24'h0, LED_data}, {24'h0, exp_q.pop_front()});
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        #1; we = 1'b1; addr = a; wd = d;
        @(negedge clk);
        #1; we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rd, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int cnt, last, flips;
    logic prev, hi_ok;

    initial begin
        rst_n = 1'b1; we = 1'b0; addr = 2'd0; wd = 32'h0;
        #1 rst_n = 1'b0;
        #2 check("reset_led_async", {24'h0, LED_data}, 32'hFF);
        idle(2);
        check("reset_led_held", {24'h0, LED_data}, 32'hFF);
        rst_n = 1'b1;
        idle(3);
        check("idle_led", {24'h0, LED_data}, 32'hFF);
        rd_chk("rst_data", 2'd0, 32'hFF);
        rd_chk("rst_blink", 2'd1, 32'h0);
        rd_chk("rst_presc", 2'd2, 32'hFFFF);
        rd_chk("rst_duty", 2'd3, 32'hF);

        // DATA write latency
        wr(2'd0, 32'hA5);
        rd_chk("data_rd_a5", 2'd0, 32'hA5);
        check("data_led_not_yet", {24'h0, LED_data}, 32'hFF);
        idle(1);
        check("data_led_a5", {24'h0, LED_data}, 32'hA5);

        // Upper write bits ignored, others untouched
        wr(2'd0, 32'hFFFF_FF3C);
        rd_chk("wide_data", 2'd0, 32'h3C);
        rd_chk("wide_blink", 2'd1, 32'h0);
        rd_chk("wide_presc", 2'd2, 32'hFFFF);
        rd_chk("wide_duty", 2'd3, 32'hF);

        // Blink: PRESC=3 gives a half-period of 4 cycles on channel 0 only
        wr(2'd2, 32'h3);
        wr(2'd1, 32'h01);
        wr(2'd0, 32'hFF);
        wr(2'd3, 32'hF);
        idle(2);
        prev = LED_data[0]; last = -1; flips = 0; hi_ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            idle(1);
            hi_ok &= &LED_data[7:1];
            if (LED_data[0] != prev) begin
                if (last >= 0) check("blink_half_period", i - last, 4);
                last = i; flips++;
            end
            prev = LED_data[0];
        end
        check("blink_flips", flips, 8);
        check("blink_others_lit", {31'h0, hi_ok}, 32'h1);

        // PWM duty 4/16, then 0, then full
        wr(2'd1, 32'h0);
        wr(2'd3, 32'h4);
        idle(2);
        cnt = 0; hi_ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            idle(1);
            if (LED_data == 8'hFF) cnt++;
            else if (LED_data != 8'h00) hi_ok = 1'b0;
        end
        check("pwm_duty4_on", cnt, 8);
        check("pwm_duty4_allornone", {31'h0, hi_ok}, 32'h1);
        wr(2'd3, 32'h0);
        idle(2);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin idle(1); if (LED_data != 8'h00) cnt++; end
        check("pwm_duty0_dark", cnt, 0);
        wr(2'd3, 32'hF);
        idle(2);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin idle(1); if (LED_data == 8'hFF) cnt++; end
        check("pwm_full_on", cnt, 16);

        // Reset mid-blink
        wr(2'd2, 32'h5);
        wr(2'd1, 32'hFF);
        wr(2'd0, 32'h5A);
        idle(7);
        #2 rst_n = 1'b0;
        #1 check("midrun_reset_led", {24'h0, LED_data}, 32'hFF);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        rd_chk("post_reset_presc", 2'd2, 32'hFFFF);
        rd_chk("post_reset_blink", 2'd1, 32'h0);
        check("post_reset_led", {24'h0, LED_data}, 32'hFF);

        // Random register traffic checked against the model
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            we   = ($urandom_range(0, 2) == 0);
            addr = 2'($urandom_range(0, 3));
            wd   = $urandom;
            if (addr == 2'd2) wd = wd & 32'hFFFF_0003;
            #1;
            check("rand_rd", rd, model_rd(addr));
        end
        we = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/led_ctrl.md
LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 Parameter NUM_LED, default 8, number of LED channels (1..32).
REQ-002 Parameter PRESC_W, default 16, blink prescaler width (1..32).
REQ-003 Parameter PWM_W, default 4, brightness counter width (1..8).
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 we  input  1  register write strobe, sampled on rising clk.
REQ-007 addr  input  2  register select: 0 DATA, 1 BLINK, 2 PRESC, 3 DUTY.
REQ-008 wd  input  32  write data.
REQ-009 rd  output  32  readback of register at addr, combinational, zero-extended.
REQ-010 LED_data  output  NUM_LED  registered LED drive, 1 = lit.

Function
REQ-011 DATA[NUM_LED-1:0] SHALL hold the static LED pattern, loaded from wd[NUM_LED-1:0] when we and addr==0.
REQ-012 BLINK[NUM_LED-1:0] SHALL hold the per-channel blink-enable mask, loaded when we and addr==1.
REQ-013 PRESC[PRESC_W-1:0] SHALL hold the prescaler reload value, loaded when we and addr==2.
REQ-014 DUTY[PWM_W-1:0] SHALL hold the global brightness, loaded when we and addr==3.
REQ-015 wd bits above the target register width SHALL be ignored; rd bits above it SHALL read 0.
REQ-016 Prescaler counter SHALL count down by 1 per cycle; on reaching 0 it SHALL reload PRESC and toggle blink_phase in the same cycle.
REQ-017 Blink period SHALL therefore be 2*(PRESC+1) cycles; PRESC==0 SHALL toggle blink_phase every cycle.
REQ-018 A PRESC write SHALL also load the prescaler counter with the new value on the same edge; blink_phase SHALL be unchanged by the write.
REQ-019 PWM counter SHALL free-run 0..2^PWM_W-1 and wrap to 0.
REQ-020 pwm_on SHALL be 1 when DUTY==2^PWM_W-1 (full on), else (pwm_cnt < DUTY); DUTY==0 SHALL force pwm_on 0.
REQ-021 Channel i next value SHALL be DATA[i] & (BLINK[i] ? blink_phase : 1) & pwm_on.
REQ-022 LED_data SHALL be registered: a register write at edge k SHALL be visible on LED_data after edge k+1 (one-cycle latency).
REQ-023 Counters SHALL keep running regardless of we; writes SHALL never stall or restart the PWM counter.
REQ-024 A write to one register SHALL leave all other registers unchanged.

Reset
REQ-025 While rst_n==0, regardless of clk: DATA all ones, BLINK 0, PRESC all ones, DUTY all ones, prescaler counter all ones, pwm_cnt 0, blink_phase 1, LED_data all ones.
REQ-026 Reset asserted mid-blink or mid-PWM period SHALL immediately force the values of REQ-025; the first edge after deassertion SHALL resume counting from those values.
REQ-027 A we asserted in the same cycle as reset deassertion edge SHALL not be required to take effect; the first edge with rst_n==1 SHALL accept writes normally.

Verification
REQ-028 Reset then idle -> LED_data = all ones, rd(addr 0..3) = 0xFF, 0x00, 0xFFFF, 0xF with defaults.
REQ-029 Write DATA=0xA5 at edge k -> rd(0)=0xA5 after edge k, LED_data=0xA5 after edge k+1.
REQ-030 PRESC=3, BLINK=0x01, DATA=0xFF, DUTY=0xF -> LED_data[0] toggles every 4 cycles (period 8), LED_data[7:1] stay 1.
REQ-031 DUTY=4, DATA=0xFF, BLINK=0 -> each LED high 4 of every 16 cycles; DUTY=0 -> LED_data=0 constantly; DUTY=0xF -> constantly 0xFF.
REQ-032 Write wd=0xFFFF_FF3C to DATA -> rd(0)=0x0000_003C, other registers unchanged.
REQ-033 Assert rst_n=0 mid-blink with PRESC=5 -> LED_data=0xFF asynchronously, PRESC reads 0xFFFF after release.
